// File: rtl/video_pkg.sv
// video_pkg: RGB565 field layout, 2x2 scaler pair-sum layout and scaler FSM states.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package video_pkg;

   // RGB565 field slices
   localparam int R_HI = 15;
   localparam int R_LO = 11;
   localparam int G_HI = 10;
   localparam int G_LO = 5;
   localparam int B_HI = 4;
   localparam int B_LO = 0;

   // Horizontal pair sums carry one extra bit per field
   localparam int SUM_RW = 6;
   localparam int SUM_GW = 7;
   localparam int SUM_BW = 6;
   localparam int SUM_W  = SUM_RW + SUM_GW + SUM_BW;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic [SUM_RW-1:0] r;
      logic [SUM_GW-1:0] g;
      logic [SUM_BW-1:0] b;
   } pair_sum_t;

   // Field-wise sum of two RGB565 pixels, widened so nothing overflows.
   function automatic pair_sum_t pair_add(input logic [15:0] a, input logic [15:0] b);
      pair_sum_t s;
      s.r = SUM_RW'(a[R_HI:R_LO]) + SUM_RW'(b[R_HI:R_LO]);
      s.g = SUM_GW'(a[G_HI:G_LO]) + SUM_GW'(b[G_HI:G_LO]);
      s.b = SUM_BW'(a[B_HI:B_LO]) + SUM_BW'(b[B_HI:B_LO]);
      return s;
   endfunction

endpackage

// File: rtl/scale_line_ram.sv
// scale_line_ram: simple dual-port line buffer holding even-row pair sums.
// Latency: write takes effect at the edge; read data registered, valid 1 cycle after i_re.
// Backpressure: none; one write and one read port, same clock.
// Ports: i_clk; i_we/i_waddr/i_wdata write port; i_re/i_raddr read request; o_rdata registered read data.
module scale_line_ram
   import video_pkg::*;
#(
   parameter int DEPTH = 640,
   parameter int AW    = 10,
   parameter int W     = SUM_W
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] r_mem [DEPTH];
   logic [W-1:0] r_rdata;

   // No reset on the array or read register so this maps onto block RAM.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/video_half_scaler.sv
// video_half_scaler: 2x2 box-filter decimator, RGB565 in -> half width/height RGB565 out.
// Latency: 1 cycle from the odd-row odd-column input pixel to wr_en/wr_data.
// Backpressure: none; the stream cannot be stalled, output rate is at most 1/2 per line.
// Ports: vin_clk/vin_rst (sync, active-high); vs_in/de_in/data_in input stream;
//        wr_fsync frame-start pulse, wr_en/wr_data scaled pixel, frame_err sticky geometry error.
module video_half_scaler
   import video_pkg::*;
#(
   parameter int H_IN      = 1280,
   parameter int V_IN      = 720,
   parameter int PIX_WIDTH = 16,
   parameter bit VS_POL    = 1'b1,
   parameter int LINE_AW   = $clog2(H_IN/2)
) (
   input  logic                 vin_clk,
   input  logic                 vin_rst,
   input  logic                 vs_in,
   input  logic                 de_in,
   input  logic [PIX_WIDTH-1:0] data_in,
   output logic                 wr_fsync,
   output logic                 wr_en,
   output logic [PIX_WIDTH-1:0] wr_data,
   output logic                 frame_err
);

   // Counters get one spare bit and saturate, so over-long lines/frames
   // never wrap back into the valid range.
   localparam int HCW = $clog2(H_IN + 1) + 1;
   localparam int VCW = $clog2(V_IN + 1) + 1;
   localparam logic [HCW-1:0] H_LIM = HCW'(H_IN);
   localparam logic [VCW-1:0] V_LIM = VCW'(V_IN);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_run;
   logic              r_vs_d;
   logic              r_de_d;
   logic              r_skip;
   logic [HCW-1:0]    r_h_cnt;
   logic [VCW-1:0]    r_v_cnt;
   logic [15:0]       r_lat;
   logic              r_fsync;
   logic              r_wr_en;
   logic [15:0]       r_wr_data;
   logic              r_err;

   logic              w_fstart;
   logic              w_de_fall;
   logic              w_pix;
   logic              w_even_px;
   logic              w_odd_px;
   logic              w_odd_row;
   pair_sum_t         w_pair;
   pair_sum_t         w_rd;
   logic [SUM_W-1:0]  w_ram_rdata;
   logic [LINE_AW-1:0] w_addr;
   logic [SUM_RW:0]   w_sum_r;
   logic [SUM_GW:0]   w_sum_g;
   logic [SUM_BW:0]   w_sum_b;
   logic [15:0]       w_out;

   assign w_fstart  = (vs_in == VS_POL) && (r_vs_d != VS_POL);
   assign w_de_fall = !de_in && r_de_d;

   // ---------------- FSM ----------------
   always_ff @(posedge vin_clk) begin
      if (vin_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_fstart) w_state_nxt = RUN;
         RUN:     w_state_nxt = RUN;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_run = (r_state == RUN);
   end

   // ---------------- datapath decode ----------------
   // The frame-start cycle and the remainder of an abandoned line never count as pixels.
   assign w_pix     = w_run && de_in && !w_fstart && !r_skip &&
                      (r_h_cnt < H_LIM) && (r_v_cnt < V_LIM);
   assign w_even_px = w_pix && !r_h_cnt[0];
   assign w_odd_px  = w_pix &&  r_h_cnt[0];
   assign w_odd_row = r_v_cnt[0];
   assign w_addr    = r_h_cnt[LINE_AW:1];
   assign w_pair    = pair_add(r_lat, data_in[15:0]);
   assign w_rd      = pair_sum_t'(w_ram_rdata);

   // Vertical sum: read issued on the even pixel lands exactly on the odd pixel.
   assign w_sum_r = {1'b0, w_rd.r} + {1'b0, w_pair.r};
   assign w_sum_g = {1'b0, w_rd.g} + {1'b0, w_pair.g};
   assign w_sum_b = {1'b0, w_rd.b} + {1'b0, w_pair.b};
   assign w_out   = {5'(w_sum_r >> 2), 6'(w_sum_g >> 2), 5'(w_sum_b >> 2)};

   scale_line_ram #(
      .DEPTH (H_IN/2),
      .AW    (LINE_AW),
      .W     (SUM_W)
   ) u_line_ram (
      .i_clk   (vin_clk),
      .i_we    (w_odd_px && !w_odd_row),
      .i_waddr (w_addr),
      .i_wdata (w_pair),
      .i_re    (w_even_px && w_odd_row),
      .i_raddr (w_addr),
      .o_rdata (w_ram_rdata)
   );

   // ---------------- counters, edges, error ----------------
   always_ff @(posedge vin_clk) begin
      if (vin_rst) begin
         // Reset the sync history to the active level so a held-active
         // vs_in is not mistaken for an edge right after reset.
         r_vs_d  <= VS_POL;
         r_de_d  <= 1'b0;
         r_skip  <= 1'b0;
         r_h_cnt <= '0;
         r_v_cnt <= '0;
         r_err   <= 1'b0;
      end else begin
         r_vs_d <= vs_in;
         r_de_d <= de_in;
         if (w_fstart) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_skip  <= de_in;
         end else if (w_de_fall) begin
            r_h_cnt <= '0;
            r_skip  <= 1'b0;
            if (!r_skip && (r_v_cnt != '1)) begin
               r_v_cnt <= r_v_cnt + VCW'(1);
            end
         end else if (de_in && !r_skip && (r_h_cnt != '1)) begin
            r_h_cnt <= r_h_cnt + HCW'(1);
         end
         if (w_run && ((w_fstart && (r_v_cnt != V_LIM)) ||
                       (!w_fstart && w_de_fall && !r_skip && (r_h_cnt != H_LIM)))) begin
            r_err <= 1'b1;
         end
      end
   end

   // ---------------- pixel latch and output register ----------------
   always_ff @(posedge vin_clk) begin
      if (vin_rst) begin
         r_lat     <= '0;
         r_fsync   <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wr_data <= '0;
      end else begin
         r_fsync <= w_fstart;
         r_wr_en <= w_odd_px && w_odd_row;
         if (w_even_px) begin
            r_lat <= data_in[15:0];
         end
         if (w_odd_px && w_odd_row) begin
            r_wr_data <= w_out;
         end
      end
   end

   assign wr_fsync  = r_fsync;
   assign wr_en     = r_wr_en;
   assign wr_data   = r_wr_data;
   assign frame_err = r_err;

endmodule

// File: tb/tb_video_half_scaler.sv
// tb_video_half_scaler: directed stimulus with a frame-level model of the 2x2 decimator.
// A VS_POL=1 and a VS_POL=0 instance see the same stream (the latter with vs inverted).
// Outputs are compared every cycle at the falling clock edge.
module tb_video_half_scaler;

   localparam int H = 8;
   localparam int V = 12;

   logic        vin_clk;
   logic        vin_rst;
   logic        vs_in;
   logic        de_in;
   logic [15:0] data_in;
   logic        wr_fsync,  wr_en,  frame_err;
   logic [15:0] wr_data;
   logic        wr_fsync0, wr_en0, frame_err0;
   logic [15:0] wr_data0;

   video_half_scaler #(.H_IN(H), .V_IN(V), .PIX_WIDTH(16), .VS_POL(1'b1)) u_dut (
      .vin_clk   (vin_clk),
      .vin_rst   (vin_rst),
      .vs_in     (vs_in),
      .de_in     (de_in),
      .data_in   (data_in),
      .wr_fsync  (wr_fsync),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .frame_err (frame_err)
   );

   video_half_scaler #(.H_IN(H), .V_IN(V), .PIX_WIDTH(16), .VS_POL(1'b0)) u_dut0 (
      .vin_clk   (vin_clk),
      .vin_rst   (vin_rst),
      .vs_in     (!vs_in),
      .de_in     (de_in),
      .data_in   (data_in),
      .wr_fsync  (wr_fsync0),
      .wr_en     (wr_en0),
      .wr_data   (wr_data0),
      .frame_err (frame_err0)
   );

   initial vin_clk = 1'b0;
   always #5 vin_clk = ~vin_clk;

   int cyc = 0;
   always @(posedge vin_clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // ---------------- model ----------------
   int          q_cyc[$];
   logic [15:0] q_dat[$];
   int          qf[$];
   logic [15:0] mem_px [0:H-1];
   logic [15:0] line_px [0:H-1];
   logic [15:0] m_data;
   int          m_err_cyc;
   bit          m_run;
   int          m_v;
   bit          chk_on = 1'b0;

   function automatic logic [15:0] avg4(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c, input logic [15:0] d);
      int r, g, bl;
      r  = int'(a[15:11]) + int'(b[15:11]) + int'(c[15:11]) + int'(d[15:11]);
      g  = int'(a[10:5])  + int'(b[10:5])  + int'(c[10:5])  + int'(d[10:5]);
      bl = int'(a[4:0])   + int'(b[4:0])   + int'(c[4:0])   + int'(d[4:0]);
      return {5'(r / 4), 6'(g / 4), 5'(bl / 4)};
   endfunction

   task automatic model_reset();
      q_cyc.delete();
      q_dat.delete();
      qf.delete();
      m_data    = 16'h0000;
      m_err_cyc = -1;
      m_run     = 1'b0;
      m_v       = 0;
   endtask

   // Called while pixel i is on the bus (sampled at the next edge).
   task automatic model_pixel(input int i);
      if (m_run && i < H && m_v < V && (i % 2) == 1) begin
         if ((m_v % 2) == 0) begin
            mem_px[i-1] = line_px[i-1];
            mem_px[i]   = line_px[i];
         end else begin
            q_cyc.push_back(cyc + 1);
            q_dat.push_back(avg4(mem_px[i-1], mem_px[i], line_px[i-1], line_px[i]));
         end
      end
   endtask

   task automatic model_line_end(input int len);
      if (m_run) begin
         if (len != H && m_err_cyc < 0) m_err_cyc = cyc + 1;
         m_v++;
      end
   endtask

   // ---------------- compare process ----------------
   int          out_cnt = 0;
   int          fs_cnt  = 0;
   logic [15:0] last_out = 16'h0000;
   bit          e_en, e_fs, e_err;

   always @(negedge vin_clk) begin
      if (chk_on) begin
         e_en = (q_cyc.size() > 0) && (q_cyc[0] == cyc);
         if (e_en) begin
            m_data = q_dat[0];
            void'(q_cyc.pop_front());
            void'(q_dat.pop_front());
         end
         e_fs = (qf.size() > 0) && (qf[0] == cyc);
         if (e_fs) void'(qf.pop_front());
         e_err = (m_err_cyc >= 0) && (cyc >= m_err_cyc);
         chk("wr_en",      32'(wr_en),      32'(e_en));
         chk("wr_data",    32'(wr_data),    32'(m_data));
         chk("wr_fsync",   32'(wr_fsync),   32'(e_fs));
         chk("frame_err",  32'(frame_err),  32'(e_err));
         chk("wr_en0",     32'(wr_en0),     32'(e_en));
         chk("wr_data0",   32'(wr_data0),   32'(m_data));
         chk("wr_fsync0",  32'(wr_fsync0),  32'(e_fs));
         chk("frame_err0", 32'(frame_err0), 32'(e_err));
         if (wr_en) begin
            out_cnt++;
            last_out = wr_data;
         end
         if (wr_fsync) fs_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge vin_clk);
      #1;
   endtask

   task automatic do_reset();
      vin_rst = 1'b1;
      de_in   = 1'b0;
      tick();
      model_reset();
      tick();
      vin_rst = 1'b0;
      tick();
   endtask

   task automatic vs_edge();
      vs_in = 1'b1;
      if (m_run && m_v != V && m_err_cyc < 0) m_err_cyc = cyc + 1;
      qf.push_back(cyc + 1);
      m_run = 1'b1;
      m_v   = 0;
      tick();
      tick();
      vs_in = 1'b0;
      tick();
      tick();
   endtask

   task automatic send_line(input int len);
      for (int i = 0; i < len; i++) begin
         de_in   = 1'b1;
         data_in = line_px[i];
         model_pixel(i);
         tick();
      end
      de_in   = 1'b0;
      data_in = 16'h0000;
      model_line_end(len);
      tick();
      tick();
      tick();
   endtask

   task automatic fill_alt(input logic [15:0] a, input logic [15:0] b);
      for (int i = 0; i < H; i++) line_px[i] = (i % 2 == 0) ? a : b;
   endtask

   task automatic fill_pat(input int row);
      for (int i = 0; i < H; i++)
         line_px[i] = 16'((row * 32'h0843) ^ (i * 32'h1111) ^ 32'h5A5A);
   endtask

   task automatic pat_lines(input int first, input int n);
      for (int r = first; r < first + n; r++) begin
         fill_pat(r);
         send_line(H);
      end
   endtask

   int o0, f0;

   initial begin
      vin_rst = 1'b1;
      vs_in   = 1'b0;
      de_in   = 1'b0;
      data_in = 16'h0000;
      for (int i = 0; i < H; i++) begin
         mem_px[i]  = 16'h0000;
         line_px[i] = 16'h0000;
      end
      model_reset();
      do_reset();
      chk_on = 1'b1;

      // reset state
      chk("rst_wr_en",  32'(wr_en),     32'h0);
      chk("rst_fsync",  32'(wr_fsync),  32'h0);
      chk("rst_data",   32'(wr_data),   32'h0);
      chk("rst_err",    32'(frame_err), 32'h0);

      // stream with no sync edge: everything discarded
      pat_lines(0, 3);
      chk("presync_out", 32'(out_cnt), 32'd0);
      chk("presync_fs",  32'(fs_cnt),  32'd0);

      // flat frame
      o0 = out_cnt;
      f0 = fs_cnt;
      vs_edge();
      fill_alt(16'hF800, 16'hF800);
      for (int r = 0; r < V; r++) send_line(H);
      chk("flat_out",  32'(out_cnt - o0), 32'((H / 2) * (V / 2)));
      chk("flat_fs",   32'(fs_cnt - f0),  32'd1);
      chk("flat_data", 32'(last_out),     32'h0000F800);
      chk("flat_err",  32'(frame_err),    32'h0);

      // block averages, varied rows, short odd line in row pair 10/11
      vs_edge();
      fill_alt(16'h0800, 16'h1800);
      send_line(H);
      fill_alt(16'h2800, 16'h3800);
      send_line(H);
      chk("blk_r", 32'(last_out), 32'h00002000);
      fill_alt(16'h07E0, 16'h07E0);
      send_line(H);
      fill_alt(16'h07E0, 16'h07C0);
      send_line(H);
      chk("blk_g", 32'(last_out), 32'h000007C0);
      pat_lines(4, 7);
      chk("pre_short_err", 32'(frame_err), 32'h0);
      o0 = out_cnt;
      fill_pat(11);
      send_line(H - 1);
      chk("short_out", 32'(out_cnt - o0), 32'(H / 2 - 1));
      chk("short_err", 32'(frame_err),    32'h1);

      // following full frame keeps the sticky flag
      vs_edge();
      pat_lines(20, V);
      chk("err_sticky", 32'(frame_err), 32'h1);

      // mid-frame reset, then restart
      vs_edge();
      pat_lines(40, 3);
      do_reset();
      chk("mrst_wr_en", 32'(wr_en),     32'h0);
      chk("mrst_fsync", 32'(wr_fsync),  32'h0);
      chk("mrst_data",  32'(wr_data),   32'h0);
      chk("mrst_err",   32'(frame_err), 32'h0);
      o0 = out_cnt;
      pat_lines(50, 2);
      chk("mrst_idle_out", 32'(out_cnt - o0), 32'd0);
      vs_edge();
      pat_lines(60, 2);
      chk("mrst_two_lines", 32'(out_cnt - o0), 32'(H / 2));

      // short frame (V-2 lines) then a new sync edge
      pat_lines(62, V - 4);
      chk("short_frame_err0", 32'(frame_err), 32'h0);
      f0 = fs_cnt;
      vs_edge();
      chk("short_frame_err", 32'(frame_err), 32'h1);
      chk("short_frame_fs",  32'(fs_cnt - f0), 32'd1);
      pat_lines(80, 2);

      chk("pending_out", 32'(q_cyc.size()), 32'd0);
      chk("pending_fs",  32'(qf.size()),    32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1);
   end

endmodule

// File: doc/video_half_scaler.md
# video_half_scaler

Single-clock 2×2 box-filter decimator in the video input domain. It sits directly upstream of the frame buffer write port: it takes a raw RGB565 stream (vsync, de, data) and emits a half-width, half-height stream on `wr_fsync`/`wr_en`/`wr_data`, ready to be written as one quadrant of the spliced output. A 1280×720 source becomes 640×360 pixels per frame, produced at one quarter of the input pixel rate.

## Interface
- `H_IN`, 1280: active pixels per input line. Must be even.
- `V_IN`, 720: active lines per input frame. Must be even.
- `PIX_WIDTH`, 16: pixel width. Only RGB565 (16) is supported.
- `VS_POL`, 1: active level of `vs_in`.
- `LINE_AW`, $clog2(H_IN/2): line-RAM address width.

Ports (one clock; reset is synchronous and active-high):
- `vin_clk` in 1: pixel clock.
- `vin_rst` in 1: synchronous, active-high reset.
- `vs_in` in 1: input vertical sync.
- `de_in` in 1: input data enable. High for exactly one contiguous run per line.
- `data_in` in 16: input pixel, {R5,G6,B5}. Valid when `de_in` is high.
- `wr_fsync` out 1: one-cycle frame-start pulse to the frame buffer.
- `wr_en` out 1: output pixel valid.
- `wr_data` out 16: scaled pixel, {R5,G6,B5}.
- `frame_err` out 1: sticky geometry error flag.

## Operation
- **Reset.** All outputs are 0 and the block enters IDLE. In IDLE, data is discarded until the first active edge of `vs_in`.
- **Frame start.** A frame starts on an active edge of `vs_in`, meaning `vs_in == VS_POL` now and `!= VS_POL` on the previous cycle.
  - Clear `h_cnt` and `v_cnt`.
  - Go to RUN.
  - Pulse `wr_fsync`.
  - A frame start while `de_in` is high abandons the current line without emitting anything.
- **Pixel counting.** `h_cnt` counts `de_in` cycles within a line. On the falling edge of `de_in`, clear `h_cnt` and increment `v_cnt`. Ignore pixels with `h_cnt ≥ H_IN` and lines with `v_cnt ≥ V_IN`.
- **Horizontal pair.**
  - When `h_cnt[0]==0`, latch the pixel.
  - When `h_cnt[0]==1`, form the pair sum: R 6 bits, G 7 bits, B 6 bits (19 bits total).
  - An unpaired last pixel (odd-length line) is dropped.
- **Even row (`v_cnt[0]==0`).** Write the pair sum to the line RAM at `h_cnt>>1`. No output is produced.
- **Odd row.**
  - Read the line RAM at `h_cnt>>1` on the even-pixel cycle.
  - On the odd-pixel cycle, add the read value to the current pair sum: R 7, G 8, B 7 bits.
  - Output `{R[6:2],G[7:2],B[6:2]}`, i.e. divide by 4 with truncation and no rounding.
- **Error reporting.** `frame_err` is set, and held until `vin_rst`, when either of these occurs:
  - a line ends with `h_cnt != H_IN`;
  - a frame start arrives in RUN with `v_cnt != V_IN`.
  - The frame start that leaves IDLE never sets it.
- **Short-line handling.** A short line still emits its complete pairs. The RAM entries it does not write keep stale data.
- **States.**
  - IDLE→RUN on a frame start.
  - RUN→RUN on every later frame start.
  - Any state→IDLE on `vin_rst`.

## Timing
- `wr_fsync` is high for exactly one cycle, the cycle after the cycle in which the active `vs_in` edge is sampled.
- `wr_en`/`wr_data` are registered. If the odd-row, odd-column input pixel is sampled at cycle N, `wr_en=1` with valid data at cycle N+1. Latency is 1 cycle.
- `wr_en` is never high on two consecutive cycles. Each line gives at most `H_IN/2` pulses; each frame gives `H_IN/2 × V_IN/2`.
- The line RAM has a 1-cycle registered read. Write on even rows and read on odd rows never target the same cycle, so there are no read/write collisions.
- `wr_data` holds its last value when `wr_en=0`.
- Reset is taken at the next edge regardless of stream state. The first `wr_en` after reset needs a new frame start followed by two lines.

## Structure
- Shared package `video_pkg`:
  - RGB565 field slice constants (R 15:11, G 10:5, B 4:0);
  - pair-sum width constants (6/7/6);
  - state enum `{IDLE, RUN}`.
- Sub-module `scale_line_ram`: simple dual-port RAM, depth `H_IN/2`, width 19, 1-cycle registered read, one write port, same clock. It infers block RAM.
- Top level holds the sync edge detect, counters, adders, output register and error flag.

## Test plan
- **Flat frame.** 1280×720 frame, all pixels 16'hF800, `vs_in` edge first → exactly one `wr_fsync`, 230400 `wr_en` pulses, every `wr_data == 16'hF800`, `frame_err == 0`.
- **Block average.** 2×2 block with R = 1, 3, 5, 7 (G = B = 0) → output R = 4, output pixel `16'h2000`. Block with G = 63, 63, 63, 62 → G = 62, by truncation.
- **Latency.** Check odd-row, odd-pixel at cycle N → `wr_en` high at N+1 only, and no `wr_en` at any time during an even row.
- **Short line.** One 1279-pixel line in row pair 10/11 → that row pair gives 639 outputs, `frame_err` rises at that line's `de_in` fall and stays 1 through following frames.
- **Pre-sync and reset.**
  - Stream `de_in`/data with no `vs_in` edge after reset → no `wr_en`, no `wr_fsync`.
  - Assert `vin_rst` mid-frame → all outputs 0 next cycle, and no `wr_en` until a new `vs_in` edge plus two lines.
- **Frame-count error.** Second frame with only 718 lines, then a `vs_in` edge → `frame_err` goes to 1 and a new `wr_fsync` still pulses. `VS_POL=0` variant → frame start is taken on the falling edge of `vs_in`.
